// File: rtl/pwm_apb_regs.sv
// APB3 register slave feeding the pwm generator: shadow period/duty registers,
// boundary-synchronous transfer to the active outputs, and an optional duty slew ramp.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_OFF  | disabled; active outputs track the shadow period and clamped duty
// ST_RUN  | enabled; outputs hold, pending shadows load on period_end
// ST_RAMP | enabled; duty steps toward the target on each period_end
module pwm_apb_regs #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic             period_end,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             pwm_enable
);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_RAMP} state_t;

  state_t           state, state_nxt;
  logic             enable, ramp_en, pending;
  logic             enable_nxt, pending_nxt;
  logic [WIDTH-1:0] period_sh, duty_sh, step_r;
  logic [WIDTH-1:0] period_nxt, duty_nxt;
  logic [WIDTH-1:0] eff, ramp_val;
  logic [WIDTH:0]   up_sum, dn_dif;
  logic             clamped, ramping;
  logic [5:0]       addr_idx;
  logic             apb_setup, apb_wr, addr_rw, addr_map, err_dec;
  logic             wr_ctrl, wr_period, wr_duty, wr_step;
  logic [31:0]      rdata_mux;

  assign PREADY     = 1'b1;
  assign pwm_enable = (state != ST_OFF);
  assign ramping    = (state == ST_RAMP);
  assign clamped    = (duty_sh > period_sh);
  assign eff        = clamped ? period_sh : duty_sh;

  assign addr_idx  = PADDR[7:2];
  assign apb_setup = PSEL & ~PENABLE;
  assign apb_wr    = PSEL & PENABLE & PWRITE;
  assign addr_rw   = (addr_idx <= 6'd3);
  assign addr_map  = (addr_idx <= 6'd5);
  assign err_dec   = ~addr_map | (PWRITE & ~addr_rw);

  assign wr_ctrl   = apb_wr & (addr_idx == 6'd0);
  assign wr_period = apb_wr & (addr_idx == 6'd1);
  assign wr_duty   = apb_wr & (addr_idx == 6'd2);
  assign wr_step   = apb_wr & (addr_idx == 6'd3);

  always_comb begin
    rdata_mux = '0;
    case (addr_idx)
      6'd0: rdata_mux[1:0]       = {ramp_en, enable};
      6'd1: rdata_mux[WIDTH-1:0] = period_sh;
      6'd2: rdata_mux[WIDTH-1:0] = duty_sh;
      6'd3: rdata_mux[WIDTH-1:0] = step_r;
      6'd4: rdata_mux[2:0]       = {clamped, ramping, pending};
      6'd5: rdata_mux[WIDTH-1:0] = duty_cycle;
      default: rdata_mux = '0;
    endcase
  end

  // Extra bit keeps the sum/difference from wrapping before the saturation compare.
  assign up_sum = {1'b0, duty_cycle} + {1'b0, step_r};
  assign dn_dif = {1'b0, duty_cycle} - {1'b0, step_r};

  always_comb begin
    if (duty_cycle < eff)
      ramp_val = (up_sum >= {1'b0, eff}) ? eff : up_sum[WIDTH-1:0];
    else
      ramp_val = (dn_dif[WIDTH] || (dn_dif <= {1'b0, eff})) ? eff : dn_dif[WIDTH-1:0];
  end

  always_comb begin
    state_nxt   = state;
    period_nxt  = period;
    duty_nxt    = duty_cycle;
    pending_nxt = pending | wr_period | wr_duty;
    enable_nxt  = wr_ctrl ? PWDATA[0] : enable;
    case (state)
      ST_OFF: begin
        period_nxt  = period_sh;
        duty_nxt    = eff;
        pending_nxt = 1'b0;
        if (enable_nxt) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (period_end && pending) begin
          period_nxt  = period_sh;
          pending_nxt = wr_period | wr_duty;
          if (ramp_en && (step_r != '0)) state_nxt = ST_RAMP;
          else                           duty_nxt  = eff;
        end
      end
      ST_RAMP: begin
        if (period_end) begin
          if (pending) begin
            period_nxt  = period_sh;
            pending_nxt = wr_period | wr_duty;
          end
          duty_nxt = (ramp_en && (step_r != '0)) ? ramp_val : eff;
          if (duty_nxt == eff) state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_OFF;
    endcase
    if (!enable_nxt) state_nxt = ST_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      enable     <= 1'b0;
      ramp_en    <= 1'b0;
      pending    <= 1'b0;
      period_sh  <= '0;
      duty_sh    <= '0;
      step_r     <= '0;
      period     <= '0;
      duty_cycle <= '0;
      PRDATA     <= '0;
      PSLVERR    <= 1'b0;
    end else begin
      state      <= state_nxt;
      enable     <= enable_nxt;
      pending    <= pending_nxt;
      period     <= period_nxt;
      duty_cycle <= duty_nxt;
      if (wr_ctrl)   ramp_en   <= PWDATA[1];
      if (wr_period) period_sh <= PWDATA[WIDTH-1:0];
      if (wr_duty)   duty_sh   <= PWDATA[WIDTH-1:0];
      if (wr_step)   step_r    <= PWDATA[WIDTH-1:0];
      if (apb_setup) begin
        PRDATA  <= rdata_mux;
        PSLVERR <= err_dec;
      end else if (!PSEL) begin
        PSLVERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_apb_regs.sv
// Directed bench for pwm_apb_regs: register access, boundary sync, clamp, ramp,
// write/period_end collision, error responses and reset mid-ramp.
module tb_pwm_apb_regs;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             PSEL, PENABLE, PWRITE;
  logic [7:0]       PADDR;
  logic [31:0]      PWDATA;
  logic [31:0]      PRDATA;
  logic             PREADY, PSLVERR;
  logic             period_end;
  logic [WIDTH-1:0] period, duty_cycle;
  logic             pwm_enable;

  int n_checks = 0;
  int n_errors = 0;

  pwm_apb_regs #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .period_end(period_end), .period(period),
    .duty_cycle(duty_cycle), .pwm_enable(pwm_enable)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic pe,
                           output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1; period_end = pe;
    err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; period_end = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    d = PRDATA; err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, 1'b0, e);
  endtask

  task automatic pulse_pe();
    @(posedge clk); #1 period_end = 1'b1;
    @(posedge clk); #1 period_end = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] ramp_up [4];
    logic [31:0] ramp_dn [4];
    ramp_up = '{32'd10, 32'd40, 32'd70, 32'd75};
    ramp_dn = '{32'd75, 32'd45, 32'd15, 32'd0};

    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; period_end = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset / idle
    check_val("rst_pwm_enable", 32'(pwm_enable), 32'd0);
    check_val("rst_pready", 32'(PREADY), 32'd1);
    check_val("rst_pslverr", 32'(PSLVERR), 32'd0);
    for (int i = 0; i < 6; i++) begin
      apb_read(8'(i * 4), rd, er);
      check_val($sformatf("rst_read_%0h", i * 4), rd, 32'd0);
    end

    // shadow sync
    wr(8'h04, 32'd100);
    wr(8'h08, 32'd25);
    wr(8'h00, 32'd1);
    check_val("sync_en", 32'(pwm_enable), 32'd1);
    check_val("sync_period", 32'(period), 32'd100);
    check_val("sync_duty0", 32'(duty_cycle), 32'd25);
    wr(8'h08, 32'd60);
    repeat (3) @(posedge clk);
    #1 check_val("sync_duty_hold", 32'(duty_cycle), 32'd25);
    apb_read(8'h10, rd, er);
    check_val("sync_pending", rd, 32'd1);
    pulse_pe();
    check_val("sync_duty_load", 32'(duty_cycle), 32'd60);
    apb_read(8'h10, rd, er);
    check_val("sync_pending_clr", rd, 32'd0);

    // clamp
    wr(8'h04, 32'd50);
    wr(8'h08, 32'd80);
    apb_read(8'h10, rd, er);
    check_val("clamp_status_pre", rd, 32'd5);
    pulse_pe();
    check_val("clamp_period", 32'(period), 32'd50);
    check_val("clamp_duty", 32'(duty_cycle), 32'd50);
    apb_read(8'h10, rd, er);
    check_val("clamp_status", rd, 32'd4);

    // ramp up then down
    wr(8'h00, 32'd0);
    check_val("off_pwm_enable", 32'(pwm_enable), 32'd0);
    wr(8'h04, 32'd100);
    wr(8'h08, 32'd10);
    wr(8'h0C, 32'd30);
    wr(8'h00, 32'd3);
    check_val("ramp_start_duty", 32'(duty_cycle), 32'd10);
    wr(8'h08, 32'd75);
    for (int i = 0; i < 4; i++) begin
      pulse_pe();
      check_val($sformatf("ramp_up_%0d", i), 32'(duty_cycle), ramp_up[i]);
      if (i == 0) begin
        apb_read(8'h10, rd, er);
        check_val("ramp_status_ramping", rd, 32'd2);
      end
    end
    apb_read(8'h10, rd, er);
    check_val("ramp_up_done", rd, 32'd0);
    wr(8'h08, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pulse_pe();
      check_val($sformatf("ramp_dn_%0d", i), 32'(duty_cycle), ramp_dn[i]);
    end
    apb_read(8'h10, rd, er);
    check_val("ramp_dn_done", rd, 32'd0);

    // write access phase coinciding with period_end
    wr(8'h00, 32'd1);
    wr(8'h08, 32'd20);
    apb_write(8'h08, 32'd33, 1'b1, er);
    check_val("coll_old_loads", 32'(duty_cycle), 32'd20);
    apb_read(8'h10, rd, er);
    check_val("coll_pending", rd, 32'd1);
    pulse_pe();
    check_val("coll_new_loads", 32'(duty_cycle), 32'd33);

    // error responses
    apb_write(8'h10, 32'd7, 1'b0, er);
    check_val("err_wr_status", 32'(er), 32'd1);
    apb_write(8'h14, 32'd9, 1'b0, er);
    check_val("err_wr_active", 32'(er), 32'd1);
    apb_read(8'h10, rd, er);
    check_val("err_status_kept", rd, 32'd0);
    check_val("err_status_ok", 32'(er), 32'd0);
    apb_read(8'h14, rd, er);
    check_val("active_read", rd, 32'd33);
    apb_read(8'h20, rd, er);
    check_val("err_rd_unmapped", 32'(er), 32'd1);
    check_val("err_rd_data", rd, 32'd0);
    apb_read(8'h0C, rd, er);
    check_val("step_readback", rd, 32'd30);

    // reset mid-ramp
    wr(8'h00, 32'd3);
    wr(8'h08, 32'd90);
    pulse_pe();
    pulse_pe();
    check_val("pre_rst_duty", 32'(duty_cycle), 32'd63);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_val("mid_rst_duty", 32'(duty_cycle), 32'd0);
    check_val("mid_rst_period", 32'(period), 32'd0);
    check_val("mid_rst_enable", 32'(pwm_enable), 32'd0);
    apb_read(8'h04, rd, er);
    check_val("mid_rst_period_sh", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, errors so far %0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_apb_regs.md
# pwm_apb_regs

APB3 register slave that sits directly upstream of the `pwm` generator and drives its `period` and `duty_cycle` inputs. Software writes to shadow registers. The block transfers them to the active outputs only at PWM period boundaries, so the generator never sees a torn period/duty pair. An optional slew ramp moves the active duty toward the target by a programmable step once per PWM period.

## Interface
- `WIDTH`, 16: width of the period, duty and step values (2..32).
- `clk` in 1: system clock, shared with `pwm`.
- `rst` in 1: synchronous, active-high reset.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB3 control.
- `PADDR` in 8: byte address; bits [1:0] are ignored.
- `PWDATA` in 32: write data; the low WIDTH bits are used.
- `PRDATA` out 32: read data, zero-extended.
- `PREADY` out 1: tied to 1 (zero wait states).
- `PSLVERR` out 1: error response.
- `period_end` in 1: one-cycle pulse from `pwm` on the last cycle of each period.
- `period` out WIDTH: active period to `pwm`.
- `duty_cycle` out WIDTH: active duty to `pwm`.
- `pwm_enable` out 1: gate for the `pwm` output.

## Operation
- Register map:
  - 0x00 CTRL, RW: bit0 `enable`, bit1 `ramp_en`.
  - 0x04 PERIOD, RW: shadow period.
  - 0x08 DUTY, RW: target duty.
  - 0x0C STEP, RW: ramp step.
  - 0x10 STATUS, RO: bit0 `pending`, bit1 `ramping`, bit2 `clamped`.
  - 0x14 ACTIVE, RO: current `duty_cycle`.
- Errors:
  - A write to STATUS/ACTIVE, or any access to an unmapped address, asserts PSLVERR in the access phase.
  - The write is ignored; an unmapped read returns 0.
- Write commit: on `PSEL & PENABLE & PWRITE`.
- Pending flag: a write to PERIOD or DUTY sets `pending`.
- Effective target: `eff = min(DUTY, PERIOD_shadow)`. `clamped` = (DUTY > PERIOD_shadow).
- FSM states:
  - OFF: `enable`=0.
    - `period`/`duty_cycle` track the shadow/`eff` every cycle; `pending` is cleared.
    - `enable` written to 1 → RUN.
  - RUN: outputs hold.
    - `period_end` with `pending` → LOAD action.
  - LOAD action (the cycle after `period_end`):
    - `period` ← shadow; `pending` ← 0.
    - If `ramp_en`=1 and STEP≠0, go to RAMP without changing duty.
    - Otherwise `duty_cycle` ← `eff`.
  - RAMP: on each `period_end`, `duty_cycle` moves toward `eff` by STEP.
    - Arithmetic is done in WIDTH+1 bits and saturates at `eff` (no overshoot, no wrap).
    - When `duty_cycle`==`eff`, return to RUN.
    - A new PERIOD/DUTY write during RAMP sets `pending`; the next `period_end` reloads `period` and retargets the ramp from the current duty.
  - Any state with `enable` written to 0 → OFF.
- `pwm_enable` = 1 in RUN and RAMP, 0 in OFF.
- `ramping` = (state==RAMP).

## Timing
- Reset values: all registers 0, `period`=0, `duty_cycle`=0, `pwm_enable`=0, `PRDATA`=0, `PSLVERR`=0; state OFF.
- APB reads:
  - PRDATA is registered in the setup phase (`PSEL & !PENABLE`) and held valid through the access phase.
  - PSLVERR is registered the same way.
- Latency:
  - Register write (OFF state) → outputs update 1 cycle after the access-phase edge.
  - `period_end` → outputs update 1 cycle later. `period` and `duty_cycle` change on the same edge.
- Simultaneous write and `period_end` in the same cycle:
  - The transfer uses the pre-write shadow.
  - The write sets `pending` and is applied at the following `period_end`.
- `enable` 0→1: outputs already equal the shadow (from OFF tracking), so no boundary wait is needed.
- `rst` asserted mid-ramp or mid-APB transfer:
  - All state returns to reset values on the next edge.
  - An in-flight write is discarded.
- `period_end` in OFF: ignored.
- STEP=0 with `ramp_en`=1: treated as an immediate load (no stuck ramp).

## Test plan
- Reset/idle:
  - Stimulus: hold `rst` 2 cycles, then read 0x00–0x14.
  - Required: all reads return 0, `pwm_enable`=0, PREADY=1.
- Shadow sync:
  - Stimulus: in OFF, write PERIOD=100, DUTY=25, then CTRL=1; then write DUTY=60 without pulsing `period_end`.
  - Required: `duty_cycle` stays 25 and STATUS.pending=1.
  - Stimulus: pulse `period_end`.
  - Required: `duty_cycle`=60 one cycle later and pending=0.
- Clamp:
  - Stimulus: PERIOD=50, DUTY=80, enabled, `period_end`.
  - Required: `duty_cycle`=50 and STATUS.clamped=1.
- Ramp:
  - Stimulus: PERIOD=100, duty 10, CTRL=3, STEP=30, DUTY=75.
  - Required: successive `period_end` pulses give 10→40→70→75, then STATUS.ramping=0.
  - Stimulus: ramp down to DUTY=0.
  - Required: 75→45→15→0, with no wrap.
- Collision:
  - Stimulus: a DUTY write access phase on the same cycle as `period_end`.
  - Required: the old value loads; the new value loads at the next `period_end`.
- Errors:
  - Stimulus: write to 0x10, then read from 0x20.
  - Required: PSLVERR=1 on both accesses, STATUS is unchanged, and the read data is 0.
